// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control FSM (fetch/decode/exec/mem/wb/halt).
// Optional cycle/retire counters are built when CTRL_FSM_PERF_EN is defined.
module ctrl_fsm #(
  parameter int unsigned STALL_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [13:0] signal,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_byte,
  output logic        iord,
  output logic        pc_src,
  output logic        alu_op,
  output logic        alu_src_a,
  output logic        mem2reg,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  reg_dst,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        bus_err,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);
  localparam logic [5:0] OP_BEQ    = 6'h04;

  state_e      state_q, state_d;
  logic [13:0] cw_q, cw_d;
  logic [5:0]  opq_q, opq_d;
  logic [7:0]  wait_q, wait_d;
  logic        bus_err_q, bus_err_d;

  // Control word fields as latched in DECODE.
  logic       cw_byte, cw_aluop, cw_sa, cw_m2r;
  logic       cw_regw, cw_memr, cw_memw;
  logic       cw_pcs, cw_pcwc, cw_pcw;
  logic [1:0] cw_sb, cw_rdst;

  assign cw_byte  = cw_q[13];
  assign cw_aluop = cw_q[12];
  assign cw_sa    = cw_q[11];
  assign cw_sb    = cw_q[10:9];
  assign cw_rdst  = cw_q[8:7];
  assign cw_m2r   = cw_q[6];
  assign cw_regw  = cw_q[5];
  assign cw_memr  = cw_q[4];
  assign cw_memw  = cw_q[3];
  assign cw_pcs   = cw_q[2];
  assign cw_pcwc  = cw_q[1];
  assign cw_pcw   = cw_q[0];

  // Raw (ungated) strobes from the decoder.
  logic       ir_we_c, pc_we_c, reg_we_c;
  logic       mem_rd_c, mem_wr_c, mem_byte_c;
  logic       iord_c, pc_src_c, alu_op_c;
  logic       alu_src_a_c, mem2reg_c, done_c;
  logic [1:0] alu_src_b_c, reg_dst_c;
  logic       stall_c, use_cw_c;
  logic [7:0] wait_inc;

  assign wait_inc = wait_q + 8'd1;

  // State and latched decode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cw_q      <= '0;
      opq_q     <= '0;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cw_q      <= cw_d;
      opq_q     <= opq_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state, stall watchdog and strobe decode.
  always_comb begin
    state_d     = state_q;
    cw_d        = cw_q;
    opq_d       = opq_q;
    wait_d      = '0;
    bus_err_d   = bus_err_q;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    reg_we_c    = 1'b0;
    mem_rd_c    = 1'b0;
    mem_wr_c    = 1'b0;
    mem_byte_c  = 1'b0;
    iord_c      = 1'b0;
    pc_src_c    = 1'b0;
    alu_op_c    = 1'b0;
    alu_src_a_c = 1'b0;
    mem2reg_c   = 1'b0;
    alu_src_b_c = 2'b00;
    reg_dst_c   = 2'b00;
    done_c      = 1'b0;
    stall_c     = 1'b0;
    use_cw_c    = (state_q == S_EXEC) ||
                  (state_q == S_MEM)  ||
                  (state_q == S_WB);

    if (use_cw_c) begin
      mem_byte_c  = cw_byte;
      alu_op_c    = cw_aluop;
      alu_src_a_c = cw_sa;
      alu_src_b_c = cw_sb;
      reg_dst_c   = cw_rdst;
      mem2reg_c   = cw_m2r;
      pc_src_c    = cw_pcs;
    end

    unique case (state_q)
      S_FETCH: begin
        mem_rd_c    = 1'b1;
        alu_src_b_c = 2'b01;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end else begin
          stall_c = 1'b1;
        end
      end
      S_DECODE: begin
        cw_d    = signal;
        opq_d   = op;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cw_pcw) begin
          pc_we_c = 1'b1;
          state_d = cw_regw ? S_WB : S_FETCH;
        end else if (cw_pcwc) begin
          pc_we_c = (opq_q == OP_BEQ) ? zero : ~zero;
          state_d = S_FETCH;
        end else if (cw_memr || cw_memw) begin
          state_d = S_MEM;
        end else if (cw_regw) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        iord_c   = 1'b1;
        mem_rd_c = cw_memr;
        mem_wr_c = cw_memw;
        if (mem_ready) begin
          state_d = cw_memr ? S_WB : S_FETCH;
        end else begin
          stall_c = 1'b1;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // Consecutive wait cycles; hitting the limit traps to HALT.
    if (stall_c) begin
      wait_d = wait_inc;
      if (wait_inc >= STALL_LIM) begin
        wait_d    = '0;
        state_d   = S_HALT;
        bus_err_d = 1'b1;
      end
    end

    done_c = use_cw_c && (state_d == S_FETCH);
  end

  // Reset forces every strobe low without waiting for a clock edge.
  assign ir_we      = ir_we_c     & ~rst;
  assign pc_we      = pc_we_c     & ~rst;
  assign reg_we     = reg_we_c    & ~rst;
  assign mem_rd     = mem_rd_c    & ~rst;
  assign mem_wr     = mem_wr_c    & ~rst;
  assign mem_byte   = mem_byte_c  & ~rst;
  assign iord       = iord_c      & ~rst;
  assign pc_src     = pc_src_c    & ~rst;
  assign alu_op     = alu_op_c    & ~rst;
  assign alu_src_a  = alu_src_a_c & ~rst;
  assign mem2reg    = mem2reg_c   & ~rst;
  assign alu_src_b  = alu_src_b_c & {2{~rst}};
  assign reg_dst    = reg_dst_c   & {2{~rst}};
  assign instr_done = done_c      & ~rst;
  assign state      = state_q;
  assign bus_err    = bus_err_q;

`ifdef CTRL_FSM_PERF_EN
  logic [31:0] cyc_q, ret_q;

  // Free-running cycle and retired-instruction counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (done_c) ret_q <= ret_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: random + directed check of ctrl_fsm
// against a cycle-level reference model.
module tb_ctrl_fsm;

  localparam int SMAX = 4;
`ifdef CTRL_FSM_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [13:0] signal;
  logic        zero, mem_ready;
  logic        ir_we, pc_we, reg_we, mem_rd, mem_wr;
  logic        mem_byte, iord, pc_src, alu_op;
  logic        alu_src_a, mem2reg;
  logic [1:0]  alu_src_b, reg_dst;
  logic [2:0]  state;
  logic        instr_done, bus_err;
  logic [31:0] cyc_cnt, ret_cnt;

  ctrl_fsm #(.STALL_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .op(op), .signal(signal),
    .zero(zero), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_byte(mem_byte),
    .iord(iord), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .mem2reg(mem2reg),
    .alu_src_b(alu_src_b), .reg_dst(reg_dst),
    .state(state), .instr_done(instr_done),
    .bus_err(bus_err), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0..5 as named by the control spec.
  int          m_ph, n_ph, m_wait, n_wait;
  logic [13:0] m_cw, n_cw;
  logic [5:0]  m_op, n_op;
  bit          m_err, n_err, e_done;
  logic [31:0] m_cyc, m_ret;
  logic [14:0] e_str;

  task automatic model_reset();
    m_ph = 0; m_wait = 0; m_cw = '0; m_op = '0;
    m_err = 0; m_cyc = '0; m_ret = '0;
  endtask

  task automatic model_eval();
    bit irw, pcw, rgw, mrd, mwr, mby, ior;
    bit psrc, aop, asa, m2r, stall;
    logic [1:0] asb, rdst;
    irw = 0; pcw = 0; rgw = 0; mrd = 0; mwr = 0;
    mby = 0; ior = 0; psrc = 0; aop = 0; asa = 0;
    m2r = 0; stall = 0; asb = 0; rdst = 0;
    n_ph = m_ph; n_cw = m_cw; n_op = m_op;
    n_wait = 0; n_err = m_err; e_done = 0;
    if (m_ph >= 2 && m_ph <= 4) begin
      mby = m_cw[13]; aop = m_cw[12]; asa = m_cw[11];
      asb = m_cw[10:9]; rdst = m_cw[8:7];
      m2r = m_cw[6]; psrc = m_cw[2];
    end
    case (m_ph)
      0: begin
        mrd = 1; asb = 2'b01;
        if (mem_ready) begin irw = 1; pcw = 1; n_ph = 1; end
        else stall = 1;
      end
      1: begin n_cw = signal; n_op = op; n_ph = 2; end
      2: begin
        if (m_cw[0]) begin
          pcw = 1; n_ph = m_cw[5] ? 4 : 0;
        end else if (m_cw[1]) begin
          pcw = (m_op == 6'h04) ? zero : !zero;
          n_ph = 0;
        end else if (m_cw[4] || m_cw[3]) n_ph = 3;
        else if (m_cw[5]) n_ph = 4;
        else n_ph = 0;
      end
      3: begin
        ior = 1; mrd = m_cw[4]; mwr = m_cw[3];
        if (mem_ready) n_ph = m_cw[4] ? 4 : 0;
        else stall = 1;
      end
      4: begin rgw = 1; n_ph = 0; end
      default: ;
    endcase
    if (stall) begin
      n_wait = m_wait + 1;
      if (n_wait >= SMAX) begin
        n_ph = 5; n_err = 1; n_wait = 0;
      end
    end
    e_done = (m_ph >= 2 && m_ph <= 4 && n_ph == 0);
    e_str = {irw, pcw, rgw, mrd, mwr, mby, ior, psrc,
             aop, asa, m2r, asb, rdst};
    if (rst) begin e_str = '0; e_done = 0; end
  endtask

  task automatic model_commit();
    if (rst) model_reset();
    else begin
      m_ph = n_ph; m_cw = n_cw; m_op = n_op;
      m_wait = n_wait; m_err = n_err;
      m_cyc = m_cyc + 32'd1;
      if (e_done) m_ret = m_ret + 32'd1;
    end
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, ".strobes"},
        {ir_we, pc_we, reg_we, mem_rd, mem_wr, mem_byte,
         iord, pc_src, alu_op, alu_src_a, mem2reg,
         alu_src_b, reg_dst}, e_str);
    chk({pfx, ".state"}, state, m_ph);
    chk({pfx, ".done"}, instr_done, e_done);
    chk({pfx, ".bus_err"}, bus_err, m_err);
    chk({pfx, ".cyc"}, cyc_cnt, PERF ? m_cyc : 32'd0);
    chk({pfx, ".ret"}, ret_cnt, PERF ? m_ret : 32'd0);
  endtask

  task automatic cycle(input string pfx);
    @(negedge clk);
    model_eval();
    check_outputs(pfx);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_in(input logic [5:0] o,
                        input logic [13:0] s,
                        input logic z, input logic r);
    op = o; signal = s; zero = z; mem_ready = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cycle("rst");
    rst = 1'b0;
  endtask

  logic [5:0]  t_op  [6];
  logic [13:0] t_sig [6];

  initial begin
    t_op[0] = 6'h00; t_sig[0] = 14'b01100010100000;
    t_op[1] = 6'h23; t_sig[1] = 14'b00110001110000;
    t_op[2] = 6'h04; t_sig[2] = 14'b00011000000010;
    t_op[3] = 6'h05; t_sig[3] = 14'b00011000000010;
    t_op[4] = 6'h03; t_sig[4] = 14'b00011100100101;
    t_op[5] = 6'h28; t_sig[5] = 14'b10110000001000;

    rst = 1'b1;
    set_in(6'h00, 14'h0, 1'b0, 1'b0);
    model_reset();
    cycle("init");
    chk("init.mem_rd", mem_rd, 1'b0);
    rst = 1'b0;

    // R-type: FETCH, DECODE, EXEC, WB.
    set_in(t_op[0], t_sig[0], 1'b0, 1'b1);
    repeat (4) cycle("rtype");
    chk("rtype.state", state, 3'd0);
    chk("rtype.cyc", cyc_cnt, PERF ? 32'd4 : 32'd0);
    chk("rtype.ret", ret_cnt, PERF ? 32'd1 : 32'd0);

    // Load with 3 wait cycles in MEM.
    set_in(t_op[1], t_sig[1], 1'b0, 1'b1);
    repeat (3) cycle("load");
    mem_ready = 1'b0;
    repeat (3) cycle("load.wait");
    mem_ready = 1'b1;
    repeat (2) cycle("load");

    // Branch taken / not taken, then jump-and-link.
    set_in(t_op[2], t_sig[2], 1'b1, 1'b1);
    repeat (3) cycle("beq");
    set_in(t_op[3], t_sig[3], 1'b1, 1'b1);
    repeat (3) cycle("bne");
    set_in(t_op[4], t_sig[4], 1'b0, 1'b1);
    repeat (4) cycle("jal");

    // Watchdog: mem_ready stuck low in FETCH.
    do_reset();
    set_in(6'h00, 14'h0, 1'b0, 1'b0);
    repeat (SMAX) cycle("stall");
    chk("stall.state", state, 3'd5);
    chk("stall.bus_err", bus_err, 1'b1);
    mem_ready = 1'b1;
    repeat (3) cycle("halt");

    // Byte store, reset hits mid-access.
    do_reset();
    set_in(t_op[5], t_sig[5], 1'b0, 1'b1);
    repeat (3) cycle("sb");
    mem_ready = 1'b0;
    @(negedge clk);
    model_eval();
    check_outputs("sb.mem");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async.mem_wr", mem_wr, 1'b0);
    chk("async.mem_byte", mem_byte, 1'b0);
    chk("async.iord", iord, 1'b0);
    chk("async.state", state, 3'd0);
    @(posedge clk);
    model_commit();
    #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    cycle("post_rst");

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      int k;
      k = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 0)
        set_in(t_op[k], t_sig[k], 1'b0, 1'b0);
      else
        set_in(6'($urandom), 14'($urandom), 1'b0, 1'b0);
      zero = 1'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 79) == 0 ||
          (m_ph == 5 && $urandom_range(0, 3) == 0)) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have parameter STALL_MAX, default 255: maximum consecutive wait cycles on mem_ready before bus error (range 1..255).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port op  in  6  opcode from the instruction register.
REQ-005 SHALL have port signal  in  14  decoded control word: 13 Membyte, 12 ALUOP, 11 SA, 10:9 SB, 8:7 RegDst, 6 Mem2Reg, 5 RegW, 4 MemR, 3 MemW, 2 PC_S, 1 PCWC, 0 PCW.
REQ-006 SHALL have port zero  in  1  ALU zero flag, valid in EXEC.
REQ-007 SHALL have port mem_ready  in  1  memory completes the current access this cycle.
REQ-008 SHALL have outputs ir_we, pc_we, reg_we, mem_rd, mem_wr, mem_byte, iord, pc_src, alu_op, alu_src_a, mem2reg, each 1 bit.
REQ-009 SHALL have outputs alu_src_b and reg_dst, each 2 bits.
REQ-010 SHALL have outputs state (3 bits), instr_done (1 bit), bus_err (1 bit).
REQ-011 SHALL have outputs cyc_cnt and ret_cnt, each 32 bits.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; state output SHALL equal the current encoding.
REQ-013 FETCH SHALL drive mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=0, pc_src=0.
REQ-014 FETCH with mem_ready=1 SHALL pulse ir_we=1 and pc_we=1 in that cycle, then go to DECODE; with mem_ready=0 it SHALL stay in FETCH.
REQ-015 DECODE SHALL last one cycle, latch signal and op into internal cw/opq, then go to EXEC.
REQ-016 In EXEC, MEM and WB, alu_op, alu_src_a, alu_src_b, reg_dst, mem2reg, mem_byte and pc_src SHALL come from cw.
REQ-017 EXEC with cw.PCW=1 SHALL pulse pc_we=1, then go to WB if cw.RegW=1, else to FETCH.
REQ-018 EXEC with cw.PCWC=1 SHALL drive pc_we=zero when opq=0x04 and pc_we=~zero otherwise, then go to FETCH.
REQ-019 Otherwise EXEC SHALL go to MEM if cw.MemR or cw.MemW, else to WB if cw.RegW, else to FETCH.
REQ-020 MEM SHALL drive iord=1, mem_rd=cw.MemR and mem_wr=cw.MemW, held until mem_ready.
REQ-021 On mem_ready in MEM, loads SHALL go to WB and stores to FETCH.
REQ-022 WB SHALL pulse reg_we=1 for exactly one cycle, then go to FETCH.
REQ-023 instr_done SHALL pulse for one cycle on every transition into FETCH from EXEC, MEM or WB.
REQ-024 A wait counter SHALL count consecutive cycles in FETCH or MEM with mem_ready=0, and clear on mem_ready or state change.
REQ-025 When the wait counter reaches STALL_MAX, the block SHALL set bus_err (sticky), drop all strobes and enter HALT.
REQ-026 HALT SHALL hold all strobes at 0 and be left only by rst.
REQ-027 Strobes not named for a state SHALL be 0 in that state.

Reset
REQ-028 While rst=1, all outputs SHALL be 0 immediately, without waiting for clk, including mem_rd in FETCH.
REQ-029 While rst=1, state, cw, opq, the wait counter, bus_err, cyc_cnt and ret_cnt SHALL be 0.
REQ-030 Reset asserted mid-access (e.g. during MEM) SHALL deassert mem_wr/mem_rd asynchronously.
REQ-031 After rst is released, the first clk edge SHALL evaluate FETCH.

Configuration
REQ-032 With CTRL_FSM_PERF_EN defined, cyc_cnt SHALL increment every non-reset cycle and ret_cnt on every instr_done; both SHALL wrap modulo 2^32.
REQ-033 Without CTRL_FSM_PERF_EN, cyc_cnt and ret_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-034 op=0x00, signal=01100010100000, mem_ready=1 -> FETCH,DECODE,EXEC,WB; reg_we=1 only in WB with reg_dst=01; instr_done in cycle 4; with macro, cyc_cnt=4, ret_cnt=1.
REQ-035 op=0x23, signal=00110001110000, mem_ready low 3 cycles in MEM -> iord=1, mem_rd=1 for 4 cycles; then WB with mem2reg=1, reg_we=1.
REQ-036 op=0x04, signal=00011000000010, zero=1 -> pc_we=1 in EXEC; op=0x05 with zero=1 -> pc_we=0; both return to FETCH.
REQ-037 op=0x03, signal=00011100100101 -> EXEC pc_we=1, pc_src=1; WB reg_we=1, reg_dst=10.
REQ-038 STALL_MAX=4, mem_ready=0 held in FETCH -> bus_err=1 and state=5 after 4 wait cycles; stays in HALT until rst.
REQ-039 op=0x28, signal=10110000001000, rst pulsed in MEM -> mem_wr and mem_byte drop during rst; state=0 after release.
